// File: rtl/wb_dl11.sv
// rtl/wb_dl11.sv - DL11-style console terminal Wishbone slave with 8N1 UART
//
// Purpose:
//   Wishbone responder for the four DL11 registers (RCSR, RBUF, XCSR, XBUF)
//   with a built-in 8N1 transmitter and receiver and level interrupt requests.
//   Optional macro WB_DL11_MAINT_EN adds XCSR bit2 MAINT (internal loopback).
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   wbs_adr_i[2:0]     byte address, [2:1] selects register
//   wbs_dat_i/o[15:0]  write data / read data (0 when no ack)
//   wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i[1:0], wbs_ack_o
//   uart_rx, uart_tx   serial in (asynchronous) / serial out, both idle high
//   irq_rx, irq_tx     receiver / transmitter interrupt requests

module wb_dl11 #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  wbs_adr_i,
    input  logic [15:0] wbs_dat_i,
    output logic [15:0] wbs_dat_o,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [1:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq_rx,
    output logic        irq_tx
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Bus and register file
    logic        r_ack;
    logic [15:0] r_dat;
    logic        r_rdone, r_rie, r_or, r_fe, r_xie, r_xrdy;
    logic [7:0]  r_rbuf;
    logic        w_maint;

    // TX FSM
    tx_state_t   r_tx_state, w_tx_state_n;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_n;
    logic [2:0]  r_tx_bit, w_tx_bit_n;
    logic [7:0]  r_tx_shift, w_tx_shift_n;
    logic        r_tx_line, w_tx_line_n;
    logic        w_tx_done;

    // RX synchroniser and FSM
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    rx_state_t   r_rx_state, w_rx_state_n;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt_n;
    logic [2:0]  r_rx_bit, w_rx_bit_n;
    logic [7:0]  r_rx_shift, w_rx_shift_n;
    logic        r_rx_fe, w_rx_fe_n;
    logic        r_rx_cpl, w_rx_cpl_n;
    logic        w_rx_in, w_rx_fall;

    // Bus decode: every side effect is qualified by the edge that raises ack
    logic        w_acc, w_wr, w_rd;
    logic [1:0]  w_reg;
    logic        w_rd_rbuf, w_wr_rcsr, w_wr_xcsr, w_wr_xbuf;
    logic [15:0] w_rdata;
    logic        w_unused;

    assign w_acc     = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_wr      = w_acc & wbs_we_i;
    assign w_rd      = w_acc & ~wbs_we_i;
    assign w_reg     = wbs_adr_i[2:1];
    assign w_rd_rbuf = w_rd && (w_reg == 2'd1);
    assign w_wr_rcsr = w_wr && (w_reg == 2'd0) && wbs_sel_i[0];
    assign w_wr_xcsr = w_wr && (w_reg == 2'd2) && wbs_sel_i[0];
    assign w_wr_xbuf = w_wr && (w_reg == 2'd3) && wbs_sel_i[0] && r_xrdy;
    assign w_unused  = &{1'b0, wbs_adr_i[0], wbs_sel_i[1], wbs_dat_i[15:8]};

`ifdef WB_DL11_MAINT_EN
    logic r_maint;
    assign w_maint = r_maint;
`else
    assign w_maint = 1'b0;
`endif

    always_comb begin
        w_rdata = 16'h0000;
        case (w_reg)
            2'd0: begin
                w_rdata[7] = r_rdone;
                w_rdata[6] = r_rie;
            end
            2'd1: begin
                w_rdata[15]  = r_or | r_fe;
                w_rdata[14]  = r_or;
                w_rdata[13]  = r_fe;
                w_rdata[7:0] = r_rbuf;
            end
            2'd2: begin
                w_rdata[7] = r_xrdy;
                w_rdata[6] = r_xie;
                w_rdata[2] = w_maint;
            end
            default: w_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_dat   <= 16'h0000;
            r_rdone <= 1'b0;
            r_rie   <= 1'b0;
            r_or    <= 1'b0;
            r_fe    <= 1'b0;
            r_rbuf  <= 8'h00;
            r_xie   <= 1'b0;
            r_xrdy  <= 1'b1;
`ifdef WB_DL11_MAINT_EN
            r_maint <= 1'b0;
`endif
        end else begin
            r_ack <= w_acc;
            r_dat <= w_rd ? w_rdata : 16'h0000;
            if (w_wr_rcsr) r_rie <= wbs_dat_i[6];
            if (w_wr_xcsr) begin
                r_xie <= wbs_dat_i[6];
`ifdef WB_DL11_MAINT_EN
                r_maint <= wbs_dat_i[2];
`endif
            end
            // A completing byte beats a concurrent RBUF read: RDONE stays set
            // and the read does not count as an overrun.
            if (r_rx_cpl) begin
                r_rbuf  <= r_rx_shift;
                r_fe    <= r_rx_fe;
                r_rdone <= 1'b1;
            end else if (w_rd_rbuf) begin
                r_rdone <= 1'b0;
            end
            if (r_rx_cpl && r_rdone && !w_rd_rbuf) r_or <= 1'b1;
            else if (w_rd_rbuf)                     r_or <= 1'b0;
            if (w_wr_xbuf)      r_xrdy <= 1'b0;
            else if (w_tx_done) r_xrdy <= 1'b1;
        end
    end

    // TX: the write edge clears XRDY; IDLE with XRDY low launches the frame
    // one clock later, so the start bit appears the clock after the write.
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt + 1'b1;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_line_n  = r_tx_line;
        w_tx_done    = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_n  = '0;
                w_tx_line_n = 1'b1;
                if (w_wr_xbuf) w_tx_shift_n = wbs_dat_i[7:0];
                if (!r_xrdy) begin
                    w_tx_state_n = TX_START;
                    w_tx_line_n  = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt == DIV_M1) begin
                    w_tx_state_n = TX_DATA;
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = 3'd0;
                    w_tx_line_n  = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == DIV_M1) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_n = TX_STOP;
                        w_tx_line_n  = 1'b1;
                    end else begin
                        w_tx_bit_n   = r_tx_bit + 3'd1;
                        w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                        w_tx_line_n  = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == DIV_M1) begin
                    w_tx_state_n = TX_IDLE;
                    w_tx_cnt_n   = '0;
                    w_tx_done    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_line  <= w_tx_line_n;
        end
    end

    // RX: loopback bypasses the synchroniser since r_tx_line is already local
    assign w_rx_in   = w_maint ? r_tx_line : r_rx_s2;
    assign w_rx_fall = r_rx_prev & ~w_rx_in;

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt + 1'b1;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_fe_n    = r_rx_fe;
        w_rx_cpl_n   = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_n = '0;
                if (w_rx_fall) w_rx_state_n = RX_START;
            end
            RX_START: begin
                if (r_rx_cnt == HALF_M1) begin
                    w_rx_cnt_n   = '0;
                    w_rx_bit_n   = 3'd0;
                    w_rx_state_n = w_rx_in ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == DIV_M1) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {w_rx_in, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
                    else                  w_rx_bit_n   = r_rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == DIV_M1) begin
                    w_rx_cnt_n   = '0;
                    w_rx_fe_n    = ~w_rx_in;
                    w_rx_cpl_n   = 1'b1;
                    w_rx_state_n = RX_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_fe    <= 1'b0;
            r_rx_cpl   <= 1'b0;
        end else begin
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= w_rx_in;
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
            r_rx_fe    <= w_rx_fe_n;
            r_rx_cpl   <= w_rx_cpl_n;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign uart_tx   = w_maint | r_tx_line;
    assign irq_rx    = r_rie & r_rdone;
    assign irq_tx    = r_xie & r_xrdy;

endmodule

// File: tb/tb_wb_dl11.sv
// tb/tb_wb_dl11.sv - self-checking bench for wb_dl11 against a register-level model
module tb_wb_dl11;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  wbs_adr_i;
    logic [15:0] wbs_dat_i;
    logic [15:0] wbs_dat_o;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [1:0]  wbs_sel_i;
    logic        wbs_ack_o;
    logic        uart_rx;
    logic        uart_tx;
    logic        irq_rx, irq_tx;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the programmer-visible state
    logic       m_rdone, m_rie, m_or, m_fe, m_xie, m_xrdy, m_maint;
    logic [7:0] m_data;

    always #5 clk = ~clk;

    wb_dl11 #(.CLK_HZ(1000000), .BAUD(100000)) dut (
        .clk(clk), .reset(reset),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_ack_o(wbs_ack_o),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .irq_rx(irq_rx), .irq_tx(irq_tx)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_rcsr();
        return {8'h00, m_rdone, m_rie, 6'b000000};
    endfunction

    function automatic logic [15:0] exp_xcsr();
        return {8'h00, m_xrdy, m_xie, 3'b000, m_maint, 2'b00};
    endfunction

    function automatic logic [15:0] exp_rbuf();
        return {m_or | m_fe, m_or, m_fe, 5'b00000, m_data};
    endfunction

    task automatic model_reset();
        m_rdone = 0; m_rie = 0; m_or = 0; m_fe = 0;
        m_xie = 0; m_xrdy = 1; m_maint = 0; m_data = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic stop_ok);
        if (m_rdone) m_or = 1;
        m_data = b; m_fe = ~stop_ok; m_rdone = 1;
    endtask

    task automatic wb_write(input logic [2:0] adr, input logic [15:0] d, input logic [1:0] sel, input string tag);
        @(negedge clk);
        wbs_adr_i = adr; wbs_dat_i = d; wbs_sel_i = sel;
        wbs_we_i = 1; wbs_cyc_i = 1; wbs_stb_i = 1;
        @(posedge clk); #1;
        check({tag, "_ack"}, {15'b0, wbs_ack_o}, 16'h0001);
        @(negedge clk);
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    endtask

    task automatic wb_read(input logic [2:0] adr, output logic [15:0] d, input string tag);
        @(negedge clk);
        wbs_adr_i = adr; wbs_sel_i = 2'b11;
        wbs_we_i = 0; wbs_cyc_i = 1; wbs_stb_i = 1;
        @(posedge clk); #1;
        check({tag, "_ack"}, {15'b0, wbs_ack_o}, 16'h0001);
        d = wbs_dat_o;
        @(negedge clk);
        wbs_cyc_i = 0; wbs_stb_i = 0;
    endtask

    task automatic chk_rcsr(input string tag);
        logic [15:0] d;
        wb_read(3'd0, d, tag);
        check(tag, d, exp_rcsr());
        check({tag, "_irq_rx"}, {15'b0, irq_rx}, {15'b0, m_rie & m_rdone});
    endtask

    task automatic chk_xcsr(input string tag);
        logic [15:0] d;
        wb_read(3'd4, d, tag);
        check(tag, d, exp_xcsr());
        check({tag, "_irq_tx"}, {15'b0, irq_tx}, {15'b0, m_xie & m_xrdy});
    endtask

    task automatic chk_rbuf(input string tag);
        logic [15:0] d;
        wb_read(3'd2, d, tag);
        check(tag, d, exp_rbuf());
        m_rdone = 0; m_or = 0;
    endtask

    // Write XBUF, then watch the serial line at each bit centre and XRDY via irq_tx
    task automatic tx_byte(input logic [7:0] b, input string tag);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        wb_write(3'd6, {8'h00, b}, 2'b11, tag);
        m_xrdy = 0;
        for (int e = 1; e <= 101; e++) begin
            @(posedge clk); #1;
            if (e % 10 == 5)
                check($sformatf("%s_bit%0d", tag, e / 10), {15'b0, uart_tx}, {15'b0, fr[e / 10]});
            if (e == 100) check({tag, "_xrdy_late"}, {15'b0, irq_tx}, 16'h0000);
        end
        m_xrdy = 1;
        check({tag, "_xrdy_101"}, {15'b0, irq_tx}, {15'b0, m_xie});
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = fr[i];
            repeat (9) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1;
        repeat (5) @(negedge clk);
        model_byte(b, stop_ok);
    endtask

    initial begin
        logic [15:0] d;
        logic [7:0]  b;
        logic        st, bad;
        int          n;

        reset = 1; uart_rx = 1; wbs_adr_i = 0; wbs_dat_i = 0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {15'b0, wbs_ack_o}, 16'h0000);
        check("rst_dat", wbs_dat_o, 16'h0000);
        check("rst_tx", {15'b0, uart_tx}, 16'h0001);
        check("rst_irq", {14'b0, irq_rx, irq_tx}, 16'h0000);
        @(negedge clk);
        reset = 0;
        chk_rcsr("rst_rcsr");
        chk_rbuf("rst_rbuf");
        chk_xcsr("rst_xcsr");

        // XIE write without byte lane 0 is ignored, then enabled properly
        wb_write(3'd4, 16'o000100, 2'b10, "xcsr_nosel");
        chk_xcsr("xcsr_nosel");
        wb_write(3'd4, 16'o000100, 2'b01, "xcsr_xie");
        m_xie = 1;
        chk_xcsr("xcsr_xie");

        // Transmit: directed 'A' then random bytes
        tx_byte(8'o101, "tx_A");
        chk_xcsr("tx_A_done");
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            tx_byte(b, $sformatf("tx_rand%0d", i));
        end

        // XRDY low mid-transfer, second XBUF write ignored
        wb_write(3'd6, 16'h00F0, 2'b11, "busy_w1");
        wb_read(3'd4, d, "busy_xcsr");
        check("busy_xcsr", d, 16'o000100);
        wb_write(3'd6, 16'h000F, 2'b11, "busy_w2");
        n = 0;
        while (!irq_tx && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("busy_done_in_time", {15'b0, irq_tx}, 16'h0001);
        bad = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (!irq_tx || !uart_tx) bad = 1;
        end
        check("busy_w2_ignored", {15'b0, bad}, 16'h0000);

        // Receive with RIE=1
        wb_write(3'd0, 16'o000100, 2'b01, "rie");
        m_rie = 1;
        rx_byte(8'h5A, 1);
        chk_rcsr("rx5a_rcsr");
        chk_rbuf("rx5a_rbuf");
        chk_rcsr("rx5a_rcsr_after");

        // Overrun
        rx_byte(8'h11, 1);
        rx_byte(8'h22, 1);
        wb_read(3'd2, d, "ovr_rbuf");
        check("ovr_rbuf", d, 16'o140042);
        check("ovr_model", d, exp_rbuf());
        m_rdone = 0; m_or = 0;
        chk_rbuf("ovr_rbuf2");

        // Framing error, then a short glitch that must change nothing
        rx_byte(8'hA5, 0);
        chk_rcsr("fe_rcsr");
        chk_rbuf("fe_rbuf");
        @(negedge clk);
        uart_rx = 0;
        repeat (3) @(negedge clk);
        uart_rx = 1;
        repeat (30) @(negedge clk);
        chk_rcsr("glitch_rcsr");
        chk_rbuf("glitch_rbuf");

        // Random frames with random stop bit and random reads
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            st = ($urandom % 4) != 0;
            rx_byte(b, st);
            chk_rcsr($sformatf("rand%0d_rcsr", i));
            if ($urandom % 2) chk_rbuf($sformatf("rand%0d_rbuf", i));
        end

`ifdef WB_DL11_MAINT_EN
        wb_write(3'd4, 16'o000104, 2'b01, "maint_on");
        m_maint = 1;
        chk_xcsr("maint_xcsr");
        wb_write(3'd6, 16'h00C3, 2'b11, "maint_xbuf");
        bad = 0;
        repeat (120) begin
            @(posedge clk); #1;
            if (!uart_tx) bad = 1;
        end
        check("maint_tx_high", {15'b0, bad}, 16'h0000);
        model_byte(8'hC3, 1);
        chk_rcsr("maint_rcsr");
        chk_rbuf("maint_rbuf");
        wb_write(3'd4, 16'o000100, 2'b01, "maint_off");
        m_maint = 0;
`endif

        // Reset in the middle of a frame
        wb_write(3'd6, 16'h0000, 2'b11, "midrst_xbuf");
        repeat (30) @(negedge clk);
        check("midrst_pre_tx", {15'b0, uart_tx}, 16'h0000);
        reset = 1;
        @(posedge clk); #1;
        check("midrst_tx", {15'b0, uart_tx}, 16'h0001);
        check("midrst_irq", {14'b0, irq_rx, irq_tx}, 16'h0000);
        @(negedge clk);
        reset = 0;
        model_reset();
        chk_xcsr("midrst_xcsr");
        chk_rcsr("midrst_rcsr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
